// File: rtl/opi_rd_pkg.sv
// Shared types and defaults for the OPI read-burst sequencer.
package opi_rd_pkg;

    // Sequencer states, 3-bit binary encoding.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD       = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_FINISH    = 3'd4,
        ST_GAP       = 3'd5
    } rd_state_t;

    // Idle cycles tolerated without command or FIFO progress.
    localparam int TIMEOUT_DEFAULT = 1023;
    // Cycles CS# stays high between bursts.
    localparam int CS_GAP_DEFAULT  = 4;
    // Width of the request tag carried in a beat.
    localparam int BEAT_ID_W       = 4;

    // One beat presented to the AXI read sink.
    typedef struct packed {
        logic [15:0]          data;
        logic                 last;
        logic [BEAT_ID_W-1:0] id;
    } rd_beat_t;

endpackage

// File: rtl/opi_rd_timeout_cnt.sv
// Watchdog: counts enabled cycles since the last clear and flags when LIMIT is reached.
module opi_rd_timeout_cnt
    import opi_rd_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_ce,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_reg;

    // Count up while enabled, saturating at LIMIT; clear has priority.
    always_ff @(posedge clk or posedge rst_ce) begin
        if (rst_ce) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && !expire) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expire = (count_reg == CW'(LIMIT));

endmodule

// File: rtl/opi_rd_sequencer.sv
// Sequences one OPI read burst through the DQ capture block and forwards popped words as beats.
module opi_rd_sequencer
    import opi_rd_pkg::*;
#(
    parameter int MEM_LEN = 9,
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CS_GAP  = CS_GAP_DEFAULT,
    parameter int ID_W    = BEAT_ID_W
) (
    input  logic               clk,
    input  logic               rst_ce,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [MEM_LEN:0]   req_len,
    input  logic [ID_W-1:0]    req_id,
    input  logic               cmd_done,
    output logic               read_state,
    output logic [MEM_LEN:0]   data_len,
    output logic               rdata_valid,
    input  logic               dqinfifo_empty,
    input  logic               dqinfifo_rd_en,
    input  logic [15:0]        dqinfifo_dout,
    input  logic               rfifo_finish,
    output logic               rd_beat_valid,
    output logic [15:0]        rd_beat_data,
    output logic               rd_beat_last,
    output logic [ID_W-1:0]    rd_beat_id,
    output logic               rd_err,
    output logic               busy
);

    // One extra bit so a full-length burst (all-ones length) never wraps the beat counter.
    localparam int BW = MEM_LEN + 2;
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    rd_state_t        state_reg, state_next;
    logic [MEM_LEN:0] data_len_reg;
    logic [ID_W-1:0]  id_reg;
    logic [BW-1:0]    beat_cnt_reg;
    logic [GW-1:0]    gap_cnt_reg;
    logic             pop_d_reg;
    rd_beat_t         beat_reg;
    logic             beat_valid_reg;
    logic             rd_err_reg;

    logic running;
    logic beat_fire;
    logic beat_is_last;
    logic tmo_expire;
    logic tmo_clr;
    logic abort;

    assign running      = (state_reg == ST_CMD) || (state_reg == ST_WAIT_DATA) || (state_reg == ST_DRAIN);
    assign beat_fire    = (state_reg == ST_DRAIN) && pop_d_reg;
    assign beat_is_last = (beat_cnt_reg == {1'b0, data_len_reg});
    // A finish report before the final beat means the capture block lost data.
    assign abort        = (running && tmo_expire) ||
                          ((state_reg == ST_DRAIN) && rfifo_finish && !(beat_fire && beat_is_last));
    assign tmo_clr      = !running || dqinfifo_rd_en || ((state_reg == ST_CMD) && cmd_done);

    opi_rd_timeout_cnt #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_ce (rst_ce),
        .clr    (tmo_clr),
        .en     (running),
        .expire (tmo_expire)
    );

    // Next-state decode; any abort in an active state jumps straight to the CS# gap.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (req_valid) state_next = ST_CMD;
            ST_CMD:       if (abort) state_next = ST_GAP;
                          else if (cmd_done) state_next = ST_WAIT_DATA;
            ST_WAIT_DATA: if (abort) state_next = ST_GAP;
                          else if (!dqinfifo_empty) state_next = ST_DRAIN;
            ST_DRAIN:     if (abort) state_next = ST_GAP;
                          else if (beat_fire && beat_is_last) state_next = ST_FINISH;
            ST_FINISH:    if (rfifo_finish) state_next = ST_GAP;
            ST_GAP:       if (gap_cnt_reg == GW'(CS_GAP - 1)) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst_ce) begin
        if (rst_ce) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Latch the request length and tag on accept.
    always_ff @(posedge clk or posedge rst_ce) begin
        if (rst_ce) begin
            data_len_reg <= '0;
            id_reg       <= '0;
        end else if ((state_reg == ST_IDLE) && req_valid) begin
            data_len_reg <= req_len;
            id_reg       <= req_id;
        end
    end

    // Beat and gap counters plus the pop delay flop that aligns with FIFO read data.
    always_ff @(posedge clk or posedge rst_ce) begin
        if (rst_ce) begin
            beat_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            pop_d_reg    <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE)      beat_cnt_reg <= '0;
            else if (beat_fire && !abort)  beat_cnt_reg <= beat_cnt_reg + 1'b1;
            gap_cnt_reg <= (state_reg == ST_GAP) ? gap_cnt_reg + 1'b1 : '0;
            pop_d_reg   <= dqinfifo_rd_en && (state_reg == ST_DRAIN);
        end
    end

    // Registered beat output and error pulse; an aborting cycle emits no beat.
    always_ff @(posedge clk or posedge rst_ce) begin
        if (rst_ce) begin
            beat_reg       <= '0;
            beat_valid_reg <= 1'b0;
            rd_err_reg     <= 1'b0;
        end else begin
            beat_valid_reg <= beat_fire && !abort;
            rd_err_reg     <= abort;
            if (beat_fire && !abort) begin
                beat_reg.data <= dqinfifo_dout;
                beat_reg.last <= beat_is_last;
                beat_reg.id   <= BEAT_ID_W'(id_reg);
            end
        end
    end

    assign req_ready     = (state_reg == ST_IDLE);
    assign busy          = (state_reg != ST_IDLE);
    assign read_state    = running || (state_reg == ST_FINISH);
    assign rdata_valid   = (state_reg == ST_DRAIN) || (state_reg == ST_FINISH);
    assign data_len      = data_len_reg;
    assign rd_beat_valid = beat_valid_reg;
    assign rd_beat_data  = beat_reg.data;
    assign rd_beat_last  = beat_reg.last;
    assign rd_beat_id    = ID_W'(beat_reg.id);
    assign rd_err        = rd_err_reg;

endmodule

// File: tb/tb_opi_rd_sequencer.sv
// Scoreboard bench for opi_rd_sequencer with a CA-engine and capture-FIFO model.
module tb_opi_rd_sequencer;
    import opi_rd_pkg::*;

    localparam int MEM_LEN = 9;
    localparam int ID_W    = 4;
    localparam int TIMEOUT = 1023;
    localparam int CS_GAP  = 4;

    logic               clk = 1'b0;
    logic               rst_ce = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [MEM_LEN:0]   req_len = '0;
    logic [ID_W-1:0]    req_id = '0;
    logic               cmd_done = 1'b0;
    logic               read_state;
    logic [MEM_LEN:0]   data_len;
    logic               rdata_valid;
    logic               dqinfifo_empty = 1'b1;
    logic               dqinfifo_rd_en;
    logic [15:0]        dqinfifo_dout = '0;
    logic               rfifo_finish = 1'b0;
    logic               rd_beat_valid;
    logic [15:0]        rd_beat_data;
    logic               rd_beat_last;
    logic [ID_W-1:0]    rd_beat_id;
    logic               rd_err;
    logic               busy;

    logic m_rd_en = 1'b0;
    logic stray_rd_en = 1'b0;
    assign dqinfifo_rd_en = m_rd_en | stray_rd_en;

    always #5 clk = ~clk;

    opi_rd_sequencer #(
        .MEM_LEN (MEM_LEN), .TIMEOUT (TIMEOUT), .CS_GAP (CS_GAP), .ID_W (ID_W)
    ) dut (
        .clk (clk), .rst_ce (rst_ce),
        .req_valid (req_valid), .req_ready (req_ready), .req_len (req_len), .req_id (req_id),
        .cmd_done (cmd_done), .read_state (read_state), .data_len (data_len),
        .rdata_valid (rdata_valid), .dqinfifo_empty (dqinfifo_empty),
        .dqinfifo_rd_en (dqinfifo_rd_en), .dqinfifo_dout (dqinfifo_dout),
        .rfifo_finish (rfifo_finish), .rd_beat_valid (rd_beat_valid),
        .rd_beat_data (rd_beat_data), .rd_beat_last (rd_beat_last), .rd_beat_id (rd_beat_id),
        .rd_err (rd_err), .busy (busy)
    );

    typedef struct {
        logic [15:0]     data;
        logic            last;
        logic [ID_W-1:0] id;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] fifo_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int beats_seen = 0;
    int err_seen = 0;

    // Model knobs set by the stimulus process.
    int cmd_delay = 0;
    int pop_limit = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    // Monitor: every presented beat is popped from the scoreboard and compared.
    always @(negedge clk) begin
        exp_t e;
        if (rd_beat_valid) begin
            beats_seen++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL beat_unexpected: got data=%h last=%b id=%h, required no beat",
                         rd_beat_data, rd_beat_last, rd_beat_id);
            end else begin
                e = exp_q.pop_front();
                if (rd_beat_data !== e.data || rd_beat_last !== e.last || rd_beat_id !== e.id) begin
                    n_bad++;
                    $display("FAIL beat: got data=%h last=%b id=%h, required data=%h last=%b id=%h",
                             rd_beat_data, rd_beat_last, rd_beat_id, e.data, e.last, e.id);
                end else begin
                    $display("beat  id=%h data=%h last=%b", rd_beat_id, rd_beat_data, rd_beat_last);
                end
            end
        end
        if (rd_err) err_seen++;
    end

    // CA-engine and capture-block model, driven on the falling edge.
    int   cmd_cnt = 0;
    logic cmd_fired = 1'b0;
    int   pops_done = 0;
    int   fin_wait = 0;
    logic pend = 1'b0;
    logic [15:0] pend_word = '0;
    always @(negedge clk) begin
        if (!read_state) begin
            cmd_cnt = 0; cmd_fired = 1'b0; pops_done = 0; fin_wait = 0;
            pend = 1'b0; cmd_done = 1'b0; m_rd_en = 1'b0; rfifo_finish = 1'b0;
        end else begin
            cmd_done = 1'b0;
            if (!cmd_fired && cmd_delay >= 0) begin
                if (cmd_cnt == cmd_delay) begin
                    cmd_done = 1'b1;
                    cmd_fired = 1'b1;
                end
                cmd_cnt++;
            end
            if (pend) begin
                dqinfifo_dout = pend_word;
                pend = 1'b0;
            end
            m_rd_en = 1'b0;
            if (rdata_valid && fifo_q.size() > 0 && pops_done < pop_limit) begin
                m_rd_en = 1'b1;
                pend_word = fifo_q.pop_front();
                pend = 1'b1;
                pops_done++;
            end
            if (rdata_valid && pops_done == pop_limit && !m_rd_en) begin
                fin_wait++;
                if (fin_wait >= 2) rfifo_finish = 1'b1;
            end
        end
        dqinfifo_empty = (fifo_q.size() == 0);
    end

    task automatic load_fifo(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + 16'(i));
    endtask

    task automatic push_exp(input int n, input logic [15:0] base, input int len, input int id);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data = base + 16'(i);
            e.last = (i == len);
            e.id   = ID_W'(id);
            exp_q.push_back(e);
        end
    endtask

    // Present a request for one cycle from IDLE; returns with the burst accepted.
    task automatic issue(input int len, input int id);
        chk("req_ready_before_issue", 32'(req_ready), 32'd1);
        req_len = MEM_LEN'(len); req_id = ID_W'(id); req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        $display("req   id=%h len=%0d", req_id, len);
        chk("read_state_after_accept", 32'(read_state), 32'd1);
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_ready(input int budget, input string what);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        chk(what, 32'(req_ready), 32'd1);
    endtask

    task automatic wait_read_low(input int budget, input string what);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!read_state) break;
        end
        chk(what, 32'(read_state), 32'd0);
    endtask

    initial begin
        int t_fall, t_rdy, t_acc, b0, e0;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_read_state", 32'(read_state), 32'd0);
        chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        chk("rst_beat_valid", 32'(rd_beat_valid), 32'd0);
        chk("rst_err_busy", {30'd0, rd_err, busy}, 32'd0);
        chk("rst_data_len", 32'(data_len), 32'd0);
        rst_ce = 1'b0;
        @(negedge clk);

        // 1: four-beat burst, gap timing
        cmd_delay = 10; pop_limit = 4;
        load_fifo(4, 16'hA001); push_exp(4, 16'hA001, 3, 1);
        @(negedge clk);
        issue(3, 1);
        chk("t1_data_len", 32'(data_len), 32'd3);
        wait_read_low(200, "t1_read_state_drop");
        t_fall = cyc;
        wait_ready(50, "t1_req_ready_return");
        t_rdy = cyc;
        chk("t1_gap_cycles", 32'(t_rdy - t_fall), 32'(CS_GAP));
        chk("t1_all_beats", 32'(exp_q.size()), 32'd0);

        // 2: single beat
        e0 = err_seen; cmd_delay = 3; pop_limit = 1;
        load_fifo(1, 16'hB0B0); push_exp(1, 16'hB0B0, 0, 2);
        @(negedge clk);
        issue(0, 2);
        chk("t2_data_len", 32'(data_len), 32'd0);
        wait_ready(200, "t2_done");
        chk("t2_all_beats", 32'(exp_q.size()), 32'd0);
        chk("t2_no_err", 32'(err_seen - e0), 32'd0);

        // 3: command never completes
        e0 = err_seen; b0 = beats_seen; cmd_delay = -1; pop_limit = 0;
        issue(2, 3);
        t_acc = cyc;
        for (int i = 0; i < TIMEOUT + 100; i++) begin
            @(negedge clk);
            if (rd_err) break;
        end
        chk("t3_err_seen", 32'(rd_err), 32'd1);
        n_cmp++;
        if ((cyc - t_acc) < TIMEOUT || (cyc - t_acc) > TIMEOUT + 2) begin
            n_bad++;
            $display("FAIL t3_timeout_latency: got %0d cycles, required %0d..%0d", cyc - t_acc, TIMEOUT, TIMEOUT + 2);
        end
        chk("t3_read_state_at_err", 32'(read_state), 32'd0);
        @(negedge clk);
        chk("t3_read_state_next", 32'(read_state), 32'd0);
        chk("t3_err_one_pulse", 32'(rd_err), 32'd0);
        wait_ready(50, "t3_idle_after_gap");
        chk("t3_err_count", 32'(err_seen - e0), 32'd1);
        chk("t3_no_beats", 32'(beats_seen - b0), 32'd0);

        // 4: premature finish after 2 of 6 beats, then stray pops
        e0 = err_seen; b0 = beats_seen; cmd_delay = 2; pop_limit = 2;
        load_fifo(6, 16'hC000); push_exp(2, 16'hC000, 5, 4);
        @(negedge clk);
        issue(5, 4);
        wait_read_low(200, "t4_abort");
        stray_rd_en = 1'b1;
        repeat (4) @(negedge clk);
        stray_rd_en = 1'b0;
        wait_ready(50, "t4_idle");
        repeat (3) @(negedge clk);
        chk("t4_err_count", 32'(err_seen - e0), 32'd1);
        chk("t4_beat_count", 32'(beats_seen - b0), 32'd2);
        chk("t4_all_beats", 32'(exp_q.size()), 32'd0);
        fifo_q.delete();
        @(negedge clk);

        // 5: reset in the middle of a 16-beat drain
        b0 = beats_seen; cmd_delay = 2; pop_limit = 16;
        load_fifo(16, 16'hD000); push_exp(16, 16'hD000, 15, 5);
        @(negedge clk);
        issue(15, 5);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (beats_seen - b0 >= 5) break;
        end
        chk("t5_reached_beat5", 32'(beats_seen - b0), 32'd5);
        rst_ce = 1'b1;
        #1;
        chk("t5_rst_read_state", 32'(read_state), 32'd0);
        chk("t5_rst_rdata_valid", 32'(rdata_valid), 32'd0);
        chk("t5_rst_beat_valid", 32'(rd_beat_valid), 32'd0);
        exp_q.delete(); fifo_q.delete();
        repeat (2) @(negedge clk);
        rst_ce = 1'b0;
        @(negedge clk);
        chk("t5_req_ready_after_rst", 32'(req_ready), 32'd1);
        pop_limit = 8;
        load_fifo(8, 16'hE000); push_exp(8, 16'hE000, 7, 6);
        @(negedge clk);
        issue(7, 6);
        wait_ready(300, "t5_new_burst_done");
        chk("t5_all_beats", 32'(exp_q.size()), 32'd0);

        // 6: req_valid held high across two bursts
        cmd_delay = 1; pop_limit = 2;
        load_fifo(2, 16'hF100); push_exp(2, 16'hF100, 1, 3);
        @(negedge clk);
        req_len = 10'd1; req_id = 4'd3; req_valid = 1'b1;
        @(negedge clk);
        chk("t6_first_accept", 32'(busy), 32'd1);
        req_len = 10'd2; req_id = 4'd9;
        push_exp(3, 16'hF200, 2, 9);
        wait_read_low(200, "t6_first_close");
        t_fall = cyc;
        load_fifo(3, 16'hF200);
        for (int i = 0; i < 50; i++) begin
            if (req_ready) break;
            @(negedge clk);
        end
        t_rdy = cyc;
        chk("t6_second_accept_gap", 32'(t_rdy - t_fall), 32'(CS_GAP));
        pop_limit = 3;
        @(negedge clk);
        req_valid = 1'b0;
        chk("t6_second_accepted", 32'(busy), 32'd1);
        wait_ready(300, "t6_second_done");
        chk("t6_all_beats", 32'(exp_q.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule
